// File: rtl/pc_fetch_stage_pkg.sv
// Shared definitions for the fetch stage: NPCOp codes, FSM states, reset PC
// and the commit-outcome classifier used by the fetch FSM.
package pc_fetch_stage_pkg;

  localparam int unsigned NPC_OP_LENGTH = 3;

  localparam logic [NPC_OP_LENGTH-1:0] NPC_OP_NEXT   = 3'd0;
  localparam logic [NPC_OP_LENGTH-1:0] NPC_OP_BRANCH = 3'd1;
  localparam logic [NPC_OP_LENGTH-1:0] NPC_OP_JUMP   = 3'd2;
  localparam logic [NPC_OP_LENGTH-1:0] NPC_OP_JR     = 3'd3;
  localparam logic [NPC_OP_LENGTH-1:0] NPC_OP_HALT   = 3'd7;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    FETCH_ST_FETCH  = 2'd0,
    FETCH_ST_VALID  = 2'd1,
    FETCH_ST_HALTED = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    COMMIT_ADVANCE = 2'd0,
    COMMIT_HALT    = 2'd1,
    COMMIT_FAULT   = 2'd2
  } commit_kind_e;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

  // Halt (explicit op or self-loop) outranks the misalignment fault.
  function automatic commit_kind_e classify_commit(
    input logic [31:0]              npc,
    input logic [NPC_OP_LENGTH-1:0] npc_op,
    input logic [31:0]              pc
  );
    if (npc_op == NPC_OP_HALT || npc == pc) return COMMIT_HALT;
    if (!is_word_aligned(npc))              return COMMIT_FAULT;
    return COMMIT_ADVANCE;
  endfunction

endpackage

// File: rtl/pc_fetch_stage_if.sv
// Instruction-memory request/ack bus between the fetch stage (master)
// and instruction memory (slave).
interface pc_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_stage.sv
// Fetch stage: architectural PC, one-at-a-time instruction fetch over req/ack,
// halt/fault detection on commit and a saturating retired-instruction counter.
import pc_fetch_stage_pkg::*;

module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              npc,
  input  logic [NPC_OP_LENGTH-1:0] npc_op,
  input  logic                     commit,
  pc_fetch_stage_if.master         imem,
  output logic [31:0]              pc,
  output logic [31:0]              instr,
  output logic                     instr_valid,
  output logic                     halted,
  output logic                     fault,
  output logic [CNT_WIDTH-1:0]     retired
);

  fetch_state_e state, state_next;
  logic [31:0]  pc_next;
  logic [31:0]  instr_next;
  logic         fault_next;
  logic         retire;
  commit_kind_e commit_kind;

  assign commit_kind    = classify_commit(npc, npc_op, pc);
  assign imem.imem_addr = pc;

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    instr_next    = instr;
    fault_next    = fault;
    retire        = 1'b0;
    imem.imem_req = 1'b0;
    unique case (state)
      FETCH_ST_FETCH: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ack) begin
          instr_next = imem.imem_rdata;
          state_next = FETCH_ST_VALID;
        end
      end
      FETCH_ST_VALID: begin
        if (commit) begin
          retire = 1'b1;
          unique case (commit_kind)
            COMMIT_HALT:  state_next = FETCH_ST_HALTED;
            COMMIT_FAULT: begin
              state_next = FETCH_ST_HALTED;
              fault_next = 1'b1;
            end
            default: begin
              pc_next    = npc;
              state_next = FETCH_ST_FETCH;
            end
          endcase
        end
      end
      FETCH_ST_HALTED: ;
      default: state_next = FETCH_ST_HALTED;
    endcase
  end

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH_ST_FETCH;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      instr       <= instr_next;
      instr_valid <= (state_next == FETCH_ST_VALID);
      halted      <= (state_next == FETCH_ST_HALTED);
      fault       <= fault_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      retired <= '0;
    else if (retire && retired != '1)
      retired <= retired + CNT_WIDTH'(1);
  end

endmodule
